fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 6, giving the FIFO word width.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 8, giving clk cycles per serial bit (legal range 2..255).
REQ-003 The block SHALL have parameter PARITY_EN, default 1: 1 = even parity bit sent, 0 = no parity bit.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port rdempty, input, 1 bit: FIFO read-side empty flag.
REQ-007 The block SHALL have port q, input, DATA_W bits: FIFO read data, valid one cycle after rdreq.
REQ-008 The block SHALL have port rdreq, output, 1 bit: FIFO read request, one-cycle pulse per word.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 The block SHALL have port frame_cnt, output, 8 bits: count of completed frames.

Function
REQ-012 The FSM SHALL have states IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
REQ-013 IDLE SHALL go to REQ when rdempty=0 at the clock edge, else stay IDLE.
REQ-014 rdreq SHALL be 1 only while in REQ (exactly one cycle), and SHALL never be 1 in any cycle entered with rdempty=1.
REQ-015 REQ SHALL go unconditionally to LOAD.
REQ-016 At the LOAD->START edge, q SHALL be captured into the shift register, and even parity (XOR of all q bits) SHALL be computed.
REQ-017 tx SHALL be 0 in START, shift-register bit 0 in DATA (LSB first), the parity bit in PARITY, and 1 in STOP, IDLE, REQ and LOAD.
REQ-018 Each of START, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles.
REQ-019 DATA SHALL last DATA_W*CLKS_PER_BIT cycles, shifting once per bit period.
REQ-020 The state after DATA SHALL be PARITY if PARITY_EN=1, else STOP.
REQ-021 STOP SHALL go to IDLE; frame_cnt SHALL increment (mod 256, 255->0) on that edge.
REQ-022 Latency: the first START cycle SHALL occur 3 cycles after the IDLE edge that sees rdempty=0.
REQ-023 Back-to-back words SHALL be separated by exactly 3 tx-high cycles (IDLE, REQ, LOAD) after the STOP bit.
REQ-024 Changes on rdempty or q outside IDLE/LOAD SHALL be ignored; a frame in progress SHALL always complete.
REQ-025 The bit-period counter SHALL restart from 0 on every state transition.

Reset
REQ-026 While rst_n=0, the block SHALL hold state=IDLE, tx=1, rdreq=0, busy=0, frame_cnt=0, shift register=0 and bit counter=0.
REQ-027 Reset mid-frame SHALL drive tx to 1 immediately (without waiting for a clock edge); the partially sent word SHALL be discarded and not re-sent.
REQ-028 After rst_n rises, the first possible rdreq SHALL be in the second cycle after release.

Structure
REQ-029 A shared package plis_pkg SHALL hold the FSM state encoding and the DATA_W default constant.
REQ-030 One sub-module, bit_timer, SHALL provide the CLKS_PER_BIT divider and produce a one-cycle bit_done pulse on restart/terminal count.
REQ-031 tx and rdreq SHALL be registered or decoded from registered state only (no combinational path from rdempty to rdreq).

Verification
REQ-032 Reset scenario: hold rst_n=0 for 5 cycles with rdempty=0 -> tx=1, rdreq=0, busy=0, frame_cnt=0 throughout.
REQ-033 Single-word scenario: CLKS_PER_BIT=4, PARITY_EN=1, q=6'b101101 -> tx bits 0,1,0,1,1,0,1,0,1 (start, data LSB first, parity, stop), each 4 cycles; one rdreq pulse; frame_cnt=1.
REQ-034 Back-to-back scenario: three words queued -> three frames, each separated by exactly 3 idle-high cycles; exactly 3 rdreq pulses; frame_cnt=3.
REQ-035 Empty FIFO scenario: rdempty=1 for 100 cycles -> rdreq never asserted; tx=1; busy=0.
REQ-036 Mid-frame reset scenario: assert rst_n=0 during DATA bit 3 -> tx=1 the same cycle; after release, the next queued word is sent intact; frame_cnt restarts at 0.
REQ-037 No-parity and wrap scenario: PARITY_EN=0, q=6'h3F -> 8 bit-period frame; run 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/plis_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state
// encoding, default word width and the even-parity helper.
package plis_pkg;

  localparam int DATA_W_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_e;

  // Even parity bit: XOR of all bits, so the word plus parity has an even
  // number of ones. Callers zero-extend narrower words.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period divider: counts clk cycles inside one serial bit and flags the
// last cycle of each period. Restart holds the count at zero.
module bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_bit_done
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] r_cnt;
  logic       w_terminal;

  assign w_terminal = (r_cnt == LAST);
  assign o_bit_done = w_terminal && !i_restart;

  // Advance the period counter, wrapping to zero at terminal count or restart
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_restart || w_terminal) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-to-UART transmitter: pops one word per frame from a show-after-read
// FIFO and sends start, data (LSB first), optional even parity and stop.
module fifo_uart_tx
  import plis_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdempty,
  input  logic [DATA_W-1:0] q,
  output logic              rdreq,
  output logic              tx,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_e            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_bit;
  logic              r_parity;
  logic              r_tx;
  logic              r_rdreq;
  logic              r_busy;
  logic [7:0]        r_frame_cnt;

  logic              w_restart;
  logic              w_bit_done;
  logic [DATA_W-1:0] w_shift_next;

  // The bit timer idles at zero until the frame's first timed state starts;
  // timed states only leave on bit_done, where the counter wraps anyway.
  assign w_restart    = (r_state == ST_IDLE) || (r_state == ST_REQ) || (r_state == ST_LOAD);
  assign w_shift_next = r_shift >> 1;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_restart  (w_restart),
    .o_bit_done (w_bit_done)
  );

  // Frame sequencer with registered line, request, busy and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit       <= '0;
      r_parity    <= 1'b0;
      r_tx        <= 1'b1;
      r_rdreq     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!rdempty) begin
            r_state <= ST_REQ;
            r_rdreq <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_REQ: begin
          r_state <= ST_LOAD;
          r_rdreq <= 1'b0;
        end
        ST_LOAD: begin
          r_state  <= ST_START;
          r_shift  <= q;
          r_parity <= even_parity(32'(q));
          r_bit    <= '0;
          r_tx     <= 1'b0;
        end
        ST_START: begin
          if (w_bit_done) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            if (r_bit == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                r_state <= ST_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + BIT_W'(1);
              r_shift <= w_shift_next;
              r_tx    <= w_shift_next[0];
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_rdreq <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx        = r_tx;
  assign rdreq     = r_rdreq;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (4 clk/bit with parity, 2 clk/bit
// without) fed from one FIFO model. A frame-timeline model predicts every
// output cycle from the frame start offset; literal checks pin the model.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic [1:0] rst_n_v = 2'b11;
  logic [1:0] rdempty_v = 2'b11;
  logic [5:0] q = 6'd0;
  wire  [1:0] rdreq_w;
  wire  [1:0] tx_w;
  wire  [1:0] busy_w;
  wire  [7:0] cnt_a;
  wire  [7:0] cnt_b;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_W(6), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n_v[0]), .rdempty(rdempty_v[0]), .q(q),
    .rdreq(rdreq_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_cnt(cnt_a));

  fifo_uart_tx #(.DATA_W(6), .CLKS_PER_BIT(2), .PARITY_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n_v[1]), .rdempty(rdempty_v[1]), .q(q),
    .rdreq(rdreq_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_cnt(cnt_b));

  // Model state: off_m = cycle offset inside the current frame (-1 = idle)
  int         off_m[2] = '{-1, -1};
  logic [5:0] word_m[2] = '{6'd0, 6'd0};
  int         cnt_m[2] = '{0, 0};
  int         frames_m[2] = '{0, 0};
  int         pulses[2] = '{0, 0};
  logic [5:0] fq[$];
  int         rises[$];
  int         sel = 0;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  bit         en = 1'b0;
  logic [1:0] busy_prev = 2'b00;
  logic [1:0] tx_s = 2'b11;

  function automatic int cpb(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int pen(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // Frame length from the start edge: REQ, LOAD, then start+6 data+[parity]+stop bits
  function automatic int flen(input int i);
    return 2 + cpb(i) * (8 + pen(i));
  endfunction

  function automatic logic exp_tx(input int o, input logic [5:0] w, input int c, input int p);
    int b;
    if (o < 2) return 1'b1;
    b = (o - 2) / c;
    if (b == 0) return 1'b0;
    if (b <= 6) return w[b-1];
    if (p != 0 && b == 7) return ^w;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  task automatic upd_empty();
    rdempty_v = 2'b11;
    if (fq.size() != 0) rdempty_v[sel] = 1'b0;
  endtask

  task automatic push(input logic [5:0] w);
    fq.push_back(w);
    upd_empty();
  endtask

  task automatic reset_model(input int i);
    off_m[i] = -1;
    cnt_m[i] = 0;
  endtask

  // One clock: sample outputs at negedge, then advance model and FIFO after posedge
  task automatic tick();
    logic [1:0] rq;
    @(negedge clk);
    rq   = rdreq_w;
    tx_s = tx_w;
    for (int i = 0; i < 2; i++) pulses[i] += int'(rq[i]);
    if (busy_w[0] && !busy_prev[0]) rises.push_back(cyc);
    busy_prev = busy_w;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n_v[i]) begin
        reset_model(i);
      end else if (off_m[i] >= 0) begin
        off_m[i]++;
        if (off_m[i] == flen(i)) begin
          off_m[i] = -1;
          cnt_m[i] = (cnt_m[i] + 1) % 256;
          frames_m[i]++;
        end
      end else if (!rdempty_v[i]) begin
        off_m[i]  = 0;
        word_m[i] = fq[0];
      end
    end
    if (rq[sel] && fq.size() != 0) q = fq.pop_front();
    else q = 6'($urandom);
    upd_empty();
  endtask

  task automatic wait_begin(input int i, input int budget);
    int k = 0;
    while (off_m[i] != 0 && k < budget) begin
      tick();
      k++;
    end
    if (off_m[i] != 0) timeout("frame_begin");
  endtask

  task automatic wait_frames(input int i, input int target, input int budget);
    int k = 0;
    while (frames_m[i] < target && k < budget) begin
      tick();
      k++;
    end
    if (frames_m[i] < target) timeout("frame_done");
  endtask

  // Per-cycle compare of both instances against the frame-timeline model
  always @(negedge clk) begin
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("tx%0d", i), int'(tx_w[i]),
              int'(exp_tx(off_m[i], word_m[i], cpb(i), pen(i))));
        check($sformatf("rdreq%0d", i), int'(rdreq_w[i]), (off_m[i] == 0) ? 1 : 0);
        check($sformatf("busy%0d", i), int'(busy_w[i]), (off_m[i] >= 0) ? 1 : 0);
        check($sformatf("frame_cnt%0d", i), int'((i == 0) ? cnt_a : cnt_b), cnt_m[i]);
      end
    end
  end

  initial begin
    logic       seq[38];
    logic [8:0] lit_a;
    logic [7:0] lit_b;
    int         f0;
    lit_a = 9'b101011010;
    lit_b = 8'b11111110;

    // Reset held 5 cycles while the FIFO is non-empty
    #1;
    rst_n_v = 2'b00;
    reset_model(0);
    reset_model(1);
    push(6'b101101);
    en = 1'b1;
    repeat (5) tick();
    #1;
    rst_n_v = 2'b11;
    pulses = '{0, 0};

    // Single word 101101, 4 clk/bit, even parity
    wait_begin(0, 10);
    for (int k = 0; k < 38; k++) begin
      tick();
      seq[k] = tx_s[0];
    end
    for (int b = 0; b < 9; b++) begin
      check($sformatf("single_bit%0d", b), int'(seq[2 + 4*b + 1]), int'(lit_a[b]));
      check($sformatf("model_pin%0d", b), int'(exp_tx(2 + 4*b + 1, 6'b101101, 4, 1)), int'(lit_a[b]));
    end
    check("single_rdreq_pulses", pulses[0], 1);
    check("single_frame_cnt", int'(cnt_a), 1);

    // Empty FIFO for 100 cycles
    pulses = '{0, 0};
    repeat (100) tick();
    check("empty_rdreq_pulses", pulses[0] + pulses[1], 0);

    // Back-to-back: three words after a fresh reset
    #1;
    rst_n_v[0] = 1'b0;
    reset_model(0);
    tick();
    tick();
    #1;
    rst_n_v[0] = 1'b1;
    pulses = '{0, 0};
    rises.delete();
    f0 = frames_m[0];
    push(6'h15);
    push(6'h2A);
    push(6'h07);
    wait_frames(0, f0 + 3, 200);
    tick();
    check("b2b_rdreq_pulses", pulses[0], 3);
    check("b2b_frame_cnt", int'(cnt_a), 3);
    check("b2b_frames", rises.size(), 3);
    if (rises.size() == 3) begin
      check("b2b_spacing1", rises[1] - rises[0], 39);
      check("b2b_spacing2", rises[2] - rises[1], 39);
    end

    // Reset during data bit 3; the following word must go out intact
    pulses = '{0, 0};
    push(6'h33);
    push(6'h0C);
    wait_begin(0, 10);
    while (off_m[0] >= 0 && off_m[0] < 19) tick();
    #1;
    rst_n_v[0] = 1'b0;
    reset_model(0);
    #1;
    check("reset_tx_async", int'(tx_w[0]), 1);
    check("reset_busy_async", int'(busy_w[0]), 0);
    repeat (3) tick();
    #1;
    rst_n_v[0] = 1'b1;
    f0 = frames_m[0];
    wait_frames(0, f0 + 1, 60);
    check("midreset_frame_cnt", int'(cnt_a), 1);
    check("midreset_rdreq_pulses", pulses[0], 2);

    // No parity, 2 clk/bit: 256 frames of 6'h3F, counter wraps
    sel = 1;
    pulses = '{0, 0};
    for (int k = 0; k < 256; k++) push(6'h3F);
    wait_begin(1, 10);
    for (int k = 0; k < 18; k++) begin
      tick();
      seq[k] = tx_s[1];
    end
    for (int b = 0; b < 8; b++)
      check($sformatf("nopar_bit%0d", b), int'(seq[2 + 2*b + 1]), int'(lit_b[b]));
    check("nopar_frame_cnt1", int'(cnt_b), 1);
    wait_frames(1, 256, 256 * 20);
    tick();
    check("wrap_frame_cnt", int'(cnt_b), 0);
    check("wrap_rdreq_pulses", pulses[1], 256);

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
